// File: rtl/regfile_dump_pkg.sv
// Shared types and default sizes for the register-file dump reader.
// Contents: FSM state encoding and default geometry constants.
// CSUM_IDX is the out_idx value carried by the checksum beat, which only
// exists when REGFILE_DUMP_CHECKSUM_EN is defined.
package regfile_dump_pkg;

  localparam int unsigned NUM_REGS_DEF = 32;
  localparam int unsigned ADDR_W_DEF   = 5;
  localparam int unsigned DATA_W_DEF   = 32;
  localparam int unsigned CSUM_IDX     = NUM_REGS_DEF;

  // Dump sequencer states; CSUM is only reachable with the checksum build.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    SEND  = 3'd2,
    CSUM  = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/regfile_dump_reader.sv
// Register-file dump reader: walks x0..NUM_REGS-1 through the shared read
// port (A1/RD1) and streams each register as one beat over valid/ready.
// While a dump is active cpu_hold freezes the core so the snapshot is
// coherent.
//
// Optional build macro REGFILE_DUMP_CHECKSUM_EN: adds an XOR accumulator of
// every sent register and one trailing checksum beat (out_idx = NUM_REGS).
//
// Ports:
//   clk, rst_n          clock (posedge) and asynchronous active-low reset
//   start               one-cycle dump request, honoured only when idle
//   rf_addr / rf_data   register-file read address and combinational data
//   cpu_hold            core freeze while the dump is active
//   busy                dump in progress, through the done pulse
//   out_valid/out_ready beat handshake
//   out_data, out_idx   beat payload and register index
//   out_last            marks the final beat of a dump
//   done                one-cycle pulse after the final beat is accepted
module regfile_dump_reader
  import regfile_dump_pkg::*;
#(
  parameter int unsigned NUM_REGS = NUM_REGS_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [DATA_W-1:0] rf_data,
  output logic              cpu_hold,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W:0]   out_idx,
  output logic              out_last,
  output logic              done
);

  localparam int unsigned IDX_W = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);
`ifdef REGFILE_DUMP_CHECKSUM_EN
  localparam logic [IDX_W-1:0] CSUM_POS = IDX_W'(NUM_REGS);
`endif

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                valid_q, valid_d;
  logic                last_q, last_d;
  logic                busy_q, busy_d;
  logic                hold_q, hold_d;
  logic                done_q, done_d;
  logic                hs;
`ifdef REGFILE_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0]   acc_q, acc_d;
`endif

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
      acc_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
`ifdef REGFILE_DUMP_CHECKSUM_EN
      acc_q   <= acc_d;
`endif
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    last_d  = last_q;
    busy_d  = busy_q;
    hold_d  = hold_q;
    done_d  = 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    acc_d   = acc_q;
`endif
    hs      = valid_q && out_ready;

    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d  = '0;
          busy_d  = 1'b1;
          hold_d  = 1'b1;
`ifdef REGFILE_DUMP_CHECKSUM_EN
          acc_d   = '0;
`endif
          state_d = FETCH;
        end
      end

      // rf_addr already shows addr_q, so RD1 is valid this cycle.
      FETCH: begin
        data_d  = rf_data;
        idx_d   = IDX_W'(addr_q);
        valid_d = 1'b1;
`ifdef REGFILE_DUMP_CHECKSUM_EN
        last_d  = 1'b0;
`else
        last_d  = (addr_q == LAST_ADDR);
`endif
        state_d = SEND;
      end

      // Payload is held untouched until the sink takes it.
      SEND: begin
        if (hs) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
          acc_d   = acc_q ^ data_q;
`endif
          if (addr_q == LAST_ADDR) begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
            state_d = CSUM;
`else
            done_d  = 1'b1;
            state_d = DONE;
`endif
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = FETCH;
          end
        end
      end

`ifdef REGFILE_DUMP_CHECKSUM_EN
      // First cycle loads the folded accumulator, then waits for acceptance.
      CSUM: begin
        if (!valid_q) begin
          data_d  = acc_q;
          idx_d   = CSUM_POS;
          last_d  = 1'b1;
          valid_d = 1'b1;
        end else if (out_ready) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
`endif

      // done is high for this one cycle; release the core on exit.
      DONE: begin
        busy_d  = 1'b0;
        hold_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign rf_addr   = addr_q;
  assign out_data  = data_q;
  assign out_idx   = idx_q;
  assign out_valid = valid_q;
  assign out_last  = last_q;
  assign busy      = busy_q;
  assign cpu_hold  = hold_q;
  assign done      = done_q;

endmodule
